// File: rtl/load_store_unit.sv
// Load/store unit: RV32I byte/halfword/word access to a word-wide data memory.
// Sub-word stores use read-modify-write. Misaligned, out-of-range or illegal accesses
// complete with resp_err and never touch memory.
`timescale 1ns/1ps
module load_store_unit #(
   parameter int unsigned DEPTH_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] data_addr,
   output logic [31:0] write_data,
   input  logic [31:0] read_data
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_READ    = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_WRITE   = 3'd3;
   localparam logic [2:0] S_RESP    = 3'd4;

   // First byte address past the end of the attached memory.
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

   logic [2:0]  state_q, state_d;
   logic        write_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wword_q;   // store data, becomes the merged word for SB/SH
   logic        err_q;
   logic [31:0] rdata_q;

   logic        accept;
   logic        code_ok;
   logic        is_half;
   logic        is_word;
   logic        req_err;
   logic [31:0] load_val;
   logic [31:0] merged;

   assign req_ready = (state_q == S_IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   assign is_half   = (funct3[1:0] == 2'b01);
   assign is_word   = (funct3[1:0] == 2'b10);

   // Classify the incoming request.
   always_comb begin
      code_ok = 1'b0;
      if (req_write) begin
         code_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end else begin
         code_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      req_err = !code_ok || (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)) ||
                ({1'b0, addr} >= ADDR_LIMIT);
   end

   // Extract and extend the addressed lane of the memory word for loads.
   always_comb begin
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      lane_b = 8'h00;
      unique case (addr_q[1:0])
         2'd0: lane_b = read_data[7:0];
         2'd1: lane_b = read_data[15:8];
         2'd2: lane_b = read_data[23:16];
         2'd3: lane_b = read_data[31:24];
      endcase
      lane_h = addr_q[1] ? read_data[31:16] : read_data[15:0];
      case (funct3_q[1:0])
         2'b00:   load_val = {{24{lane_b[7] & ~funct3_q[2]}}, lane_b};
         2'b01:   load_val = {{16{lane_h[15] & ~funct3_q[2]}}, lane_h};
         default: load_val = read_data;
      endcase
   end

   // Replace only the addressed byte/halfword of the read word for SB/SH.
   always_comb begin
      merged = read_data;
      if (funct3_q[1:0] == 2'b01) begin
         if (addr_q[1]) merged[31:16] = wword_q[15:0];
         else           merged[15:0]  = wword_q[15:0];
      end else begin
         unique case (addr_q[1:0])
            2'd0: merged[7:0]   = wword_q[7:0];
            2'd1: merged[15:8]  = wword_q[7:0];
            2'd2: merged[23:16] = wword_q[7:0];
            2'd3: merged[31:24] = wword_q[7:0];
         endcase
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (req_err)                  state_d = S_RESP;
               else if (req_write && is_word) state_d = S_WRITE;
               else                          state_d = S_READ;
            end
         end
         S_READ:    state_d = S_CAPTURE;
         S_CAPTURE: state_d = write_q ? S_WRITE : S_RESP;
         S_WRITE:   state_d = S_RESP;
         S_RESP:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // State, request latch, merge buffer and load result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         write_q  <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wword_q  <= 32'h0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            write_q  <= req_write;
            funct3_q <= funct3;
            addr_q   <= addr;
            wword_q  <= wdata;
            err_q    <= req_err;
            if (req_err) rdata_q <= 32'h0;
         end
         if (state_q == S_CAPTURE) begin
            if (write_q) wword_q <= merged;
            else         rdata_q <= load_val;
         end
         if (state_q == S_WRITE) rdata_q <= 32'h0;
      end
   end

   // Outputs; reset gates memory strobes in the same cycle.
   always_comb begin
      mem_read   = (state_q == S_READ) && !reset;
      mem_write  = (state_q == S_WRITE) && !reset;
      resp_valid = (state_q == S_RESP) && !reset;
      resp_err   = resp_valid && err_q;
      resp_rdata = reset ? 32'h0 : rdata_q;
      data_addr  = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;
      write_data = mem_write ? wword_q : 32'h0;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 32, giving the number of 32-bit words in the attached data memory.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: CPU access request.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-006 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port funct3, input, 3 bits: RV32I width/sign code.
REQ-008 The block SHALL have port addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port resp_err, output, 1 bit: the completed access was rejected.
REQ-012 The block SHALL have port resp_rdata, output, 32 bits: extended load result.
REQ-013 The block SHALL have port mem_read, output, 1 bit: data memory read enable.
REQ-014 The block SHALL have port mem_write, output, 1 bit: data memory write enable.
REQ-015 The block SHALL have port data_addr, output, 32 bits: word-aligned memory address.
REQ-016 The block SHALL have port write_data, output, 32 bits: full word to write.
REQ-017 The block SHALL have port read_data, input, 32 bits: memory word, registered by the memory on the edge that samples mem_read.

Function
REQ-018 FSM states SHALL be IDLE, READ, CAPTURE, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 On req_valid && req_ready, the block SHALL latch req_write, funct3, addr and wdata; this is cycle 0.
REQ-020 Legal codes SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other code is illegal.
REQ-021 An access SHALL be an error if any of these holds: illegal code; halfword with addr[0]=1; word with addr[1:0]!=0; addr >= DEPTH_WORDS*4.
REQ-022 On an error, the FSM SHALL go IDLE->RESP with resp_err=1, and mem_read and mem_write SHALL stay 0 throughout.
REQ-023 Loads SHALL take the path IDLE->READ->CAPTURE->RESP: mem_read=1 in cycle 1, result captured in cycle 2, resp_valid in cycle 3.
REQ-024 SW SHALL take the path IDLE->WRITE->RESP: mem_write=1 in cycle 1 with write_data=wdata, resp_valid in cycle 2.
REQ-025 SB and SH SHALL read-modify-write via IDLE->READ->CAPTURE->WRITE->RESP: mem_read in cycle 1, merge in cycle 2, mem_write in cycle 3, resp_valid in cycle 4.
REQ-026 The merge SHALL replace only the addressed byte (addr[1:0]) or halfword (addr[1]) of the read word with the low bits of wdata; all other bytes are preserved.
REQ-027 data_addr SHALL equal {addr[31:2],2'b00} whenever mem_read or mem_write is 1, and SHALL be 0 otherwise.
REQ-028 write_data SHALL be 0 whenever mem_write is 0.
REQ-029 Load extraction SHALL select the byte by addr[1:0] and the halfword by addr[1]; LB and LH sign-extend, LBU and LHU zero-extend.
REQ-030 mem_read and mem_write SHALL never both be 1, and each SHALL be high for exactly one cycle per access.
REQ-031 resp_valid SHALL be high for exactly one cycle (the RESP state), after which the FSM SHALL return to IDLE.
REQ-032 resp_rdata SHALL hold its value until the next load response; store and error responses SHALL set it to 0.
REQ-033 resp_err SHALL be valid only while resp_valid=1 and SHALL be 0 otherwise.
REQ-034 req_valid asserted in a non-IDLE state SHALL be ignored; the request is not queued.
REQ-035 The minimum spacing between accepted requests SHALL be the response cycle plus one IDLE cycle.

Reset
REQ-036 While reset=1, the block SHALL force state IDLE and set resp_valid, resp_err, resp_rdata, mem_read, mem_write, data_addr and write_data to 0; req_ready SHALL be 0 during reset.
REQ-037 mem_read and mem_write SHALL be gated by reset combinationally, so that reset asserted in READ or WRITE produces no memory access in that cycle.
REQ-038 The block SHALL accept requests from the first cycle after reset deasserts.

Verification
REQ-039 The bench SHALL cover: memory word 2 = 0x8899AABB; LB addr 0x0B -> mem_read cycle 1, data_addr 0x08; resp_valid cycle 3, resp_rdata 0xFFFFFF88, resp_err 0.
REQ-040 The bench SHALL cover: LHU addr 0x0A -> resp_rdata 0x00008899; LH addr 0x0A -> 0xFFFF8899; LW addr 0x08 -> 0x8899AABB.
REQ-041 The bench SHALL cover: SB addr 0x09, wdata 0x123456CC -> mem_write cycle 3, write_data 0x8899CCBB; resp_valid cycle 4.
REQ-042 The bench SHALL cover: SW addr 0x0C, wdata 0xDEADBEEF -> mem_write cycle 1, data_addr 0x0C; resp_valid cycle 2, resp_rdata 0.
REQ-043 The bench SHALL cover: LW addr 0x06, SH addr 0x03, LB addr 0x80 and funct3 011 -> each gives resp_valid=1, resp_err=1 in cycle 1, with no mem_read or mem_write.
REQ-044 The bench SHALL cover: reset asserted in the WRITE cycle of an SB -> mem_write stays 0, state IDLE and req_ready=1 on the first cycle after reset drops, and memory word 2 is unchanged.
